// File: rtl/ik_swift_master_0_b2p_if.sv
// ----------------------------------------------------------------------------
// ik_swift_master_0_b2p_if
//
// Byte-in / packet-beat-out stream bundle for the SWIFT bytes-to-packets
// converter.
//
//   in_ready / in_valid / in_data  : escaped byte stream from the host
//   out_ready / out_valid / out_*  : unescaped beats with packet sideband
//
// Modports:
//   master : the side that sources bytes and sinks beats (host / testbench)
//   slave  : the converter itself
// ----------------------------------------------------------------------------
interface ik_swift_master_0_b2p_if #(
   parameter int unsigned CHANNEL_WIDTH = 8
);

   logic                     in_ready;
   logic                     in_valid;
   logic [7:0]               in_data;

   logic                     out_ready;
   logic                     out_valid;
   logic [7:0]               out_data;
   logic [CHANNEL_WIDTH-1:0] out_channel;
   logic                     out_startofpacket;
   logic                     out_endofpacket;

   modport master (
      input  in_ready,
      output in_valid,
      output in_data,
      output out_ready,
      input  out_valid,
      input  out_data,
      input  out_channel,
      input  out_startofpacket,
      input  out_endofpacket
   );

   modport slave (
      output in_ready,
      input  in_valid,
      input  in_data,
      input  out_ready,
      output out_valid,
      output out_data,
      output out_channel,
      output out_startofpacket,
      output out_endofpacket
   );

endinterface

// File: rtl/ik_swift_master_0_b2p.sv
// ----------------------------------------------------------------------------
// ik_swift_master_0_b2p
//
// Avalon-ST bytes-to-packets converter for the SWIFT master path. Parses the
// host's escaped byte stream, strips the framing characters
//   0x7A SOP, 0x7B EOP, 0x7C CHANNEL, 0x7D ESCAPE
// and emits one payload byte per beat with start/end-of-packet and channel.
//
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : ik_swift_master_0_b2p_if.slave (byte input, beat output)
//
// Parameters:
//   CHANNEL_WIDTH : width of out_channel; channel values are truncated to it
//
// Build options:
//   B2P_ENCODED_CHANNEL_EN : when defined, the channel field is a
//     variable-length big-endian sequence of 7-bit groups (bit7 = more bytes
//     follow). When undefined, the channel field is a single raw byte.
//
// Output beats sit in a single register stage; in_ready is combinational
// from that register's state and out_ready only, so in_data never reaches
// the outputs combinationally.
// ----------------------------------------------------------------------------
module ik_swift_master_0_b2p #(
   parameter int unsigned CHANNEL_WIDTH = 8
) (
   input logic                    clk,
   input logic                    reset_n,
   ik_swift_master_0_b2p_if.slave bus
);

   localparam logic [7:0] SopChar  = 8'h7A;
   localparam logic [7:0] EopChar  = 8'h7B;
   localparam logic [7:0] ChanChar = 8'h7C;
   localparam logic [7:0] EscChar  = 8'h7D;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic                     esc_pend_q,  esc_pend_d;
   logic                     chan_pend_q, chan_pend_d;
   logic                     sop_pend_q,  sop_pend_d;
   logic                     eop_pend_q,  eop_pend_d;
   logic [CHANNEL_WIDTH-1:0] chan_q,      chan_d;

`ifdef B2P_ENCODED_CHANNEL_EN
   // Only the low CHANNEL_WIDTH bits of the accumulated value can ever reach
   // chan_q, so higher groups are shifted out rather than stored.
   logic [CHANNEL_WIDTH-1:0] chan_acc_q,  chan_acc_d;
   logic [CHANNEL_WIDTH-1:0] chan_acc_next;
`endif

   logic                     out_valid_q, out_valid_d;
   logic [7:0]               out_data_q,  out_data_d;
   logic [CHANNEL_WIDTH-1:0] out_chan_q,  out_chan_d;
   logic                     out_sop_q,   out_sop_d;
   logic                     out_eop_q,   out_eop_d;

   // ---------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------
   logic       in_ready;
   logic       accept;
   logic       literal;
   logic [7:0] lit_byte;

   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;

   // ---------------------------------------------------------------------
   // Byte decode
   // ---------------------------------------------------------------------
   always_comb begin
      literal  = 1'b0;
      lit_byte = bus.in_data;
      if (accept) begin
         if (esc_pend_q) begin
            // Escaped byte is always payload, even if it decodes to a marker.
            literal  = 1'b1;
            lit_byte = bus.in_data ^ 8'h20;
         end else begin
            unique case (bus.in_data)
               SopChar, EopChar, ChanChar, EscChar: literal = 1'b0;
               default:                             literal = 1'b1;
            endcase
         end
      end
   end

`ifdef B2P_ENCODED_CHANNEL_EN
   assign chan_acc_next = CHANNEL_WIDTH'({chan_acc_q, lit_byte[6:0]});
`endif

   // ---------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------
   always_comb begin
      esc_pend_d  = esc_pend_q;
      chan_pend_d = chan_pend_q;
      sop_pend_d  = sop_pend_q;
      eop_pend_d  = eop_pend_q;
      chan_d      = chan_q;
`ifdef B2P_ENCODED_CHANNEL_EN
      chan_acc_d  = chan_acc_q;
`endif

      // A completed output handshake empties the register unless a new beat
      // is loaded below in the same cycle.
      out_valid_d = out_valid_q && !bus.out_ready;
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;

      if (accept) begin
         if (esc_pend_q) begin
            esc_pend_d = 1'b0;
         end else begin
            unique case (bus.in_data)
               EscChar: esc_pend_d = 1'b1;
               SopChar: sop_pend_d = 1'b1;
               EopChar: eop_pend_d = 1'b1;
               ChanChar: begin
                  chan_pend_d = 1'b1;
`ifdef B2P_ENCODED_CHANNEL_EN
                  chan_acc_d  = '0;
`endif
               end
               default: ;
            endcase
         end

         if (literal) begin
            if (chan_pend_q) begin
`ifdef B2P_ENCODED_CHANNEL_EN
               if (lit_byte[7]) begin
                  chan_acc_d = chan_acc_next;
               end else begin
                  chan_d      = chan_acc_next;
                  chan_pend_d = 1'b0;
               end
`else
               chan_d      = CHANNEL_WIDTH'(lit_byte);
               chan_pend_d = 1'b0;
`endif
            end else begin
               out_valid_d = 1'b1;
               out_data_d  = lit_byte;
               out_chan_d  = chan_q;
               out_sop_d   = sop_pend_q;
               out_eop_d   = eop_pend_q;
               sop_pend_d  = 1'b0;
               eop_pend_d  = 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         esc_pend_q  <= 1'b0;
         chan_pend_q <= 1'b0;
         sop_pend_q  <= 1'b0;
         eop_pend_q  <= 1'b0;
         chan_q      <= '0;
`ifdef B2P_ENCODED_CHANNEL_EN
         chan_acc_q  <= '0;
`endif
         out_valid_q <= 1'b0;
         out_data_q  <= 8'h00;
         out_chan_q  <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
      end else begin
         esc_pend_q  <= esc_pend_d;
         chan_pend_q <= chan_pend_d;
         sop_pend_q  <= sop_pend_d;
         eop_pend_q  <= eop_pend_d;
         chan_q      <= chan_d;
`ifdef B2P_ENCODED_CHANNEL_EN
         chan_acc_q  <= chan_acc_d;
`endif
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.in_ready          = in_ready;
   assign bus.out_valid         = out_valid_q;
   assign bus.out_data          = out_data_q;
   assign bus.out_channel       = out_chan_q;
   assign bus.out_startofpacket = out_sop_q;
   assign bus.out_endofpacket   = out_eop_q;

endmodule
